// File: rtl/aes_stream_feeder.sv
// Streaming wrapper for the iterative AES-128 core. It buffers plaintext in a FIFO,
// issues one block at a time to the core, and holds each ciphertext with valid/ready.
module aes_stream_feeder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_load,
   input  logic [127:0]       key_in,
   output logic               key_ready,
   input  logic               in_valid,
   input  logic [127:0]       in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [127:0]       out_data,
   input  logic               out_ready,
   output logic               core_start,
   output logic [127:0]       core_key,
   output logic [127:0]       core_block,
   input  logic               core_busy,
   input  logic               core_valid,
   input  logic [127:0]       core_block_out,
   output logic [CNT_W-1:0]   blk_cnt,
   output logic               key_err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t       state, state_nxt;
   logic [127:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         full, empty, push, pop, capture, in_flight, key_wr;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready  = !full;
   assign push      = in_valid && !full;
   assign key_ready = empty && !in_flight && !core_busy && !out_valid;
   assign key_wr    = key_load && key_ready;
   // A result pulse only counts while a block is outstanding; strays after reset drop here.
   assign capture   = in_flight && core_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !in_flight && !core_busy && !out_valid && !core_start) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = capture ? IDLE : WAIT;
         WAIT:    if (capture) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         in_flight  <= 1'b0;
         out_valid  <= 1'b0;
         core_start <= 1'b0;
         blk_cnt    <= '0;
         key_err    <= 1'b0;
         out_data   <= '0;
         core_key   <= '0;
         core_block <= '0;
      end else begin
         core_start <= pop;
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) begin
            rd_ptr     <= rd_ptr + (AW+1)'(1);
            core_block <= mem[rd_ptr[AW-1:0]];
            in_flight  <= 1'b1;
         end
         // Issue waits for an empty output register, so capture never overwrites a held result.
         if (capture) begin
            out_data  <= core_block_out;
            out_valid <= 1'b1;
            in_flight <= 1'b0;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready) blk_cnt <= blk_cnt + CNT_W'(1);
         if (key_wr) core_key <= key_in;
         else if (key_load) key_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_aes_stream_feeder.sv
// Directed bench for aes_stream_feeder with a behavioural stub core (fixed latency,
// FIPS-197 vector for the known key/block pair, block^key otherwise).
module tb_aes_stream_feeder;
   localparam int DEPTH = 4;
   localparam int CNT_W = 32;
   localparam int LAT   = 6;
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] K3 = 128'h0f0e0d0c0b0a09080706050403020100;

   logic clk = 1'b0;
   logic rst_n, key_load, key_ready, in_valid, in_ready, out_valid, out_ready;
   logic core_start, core_key_dummy;
   logic [127:0] key_in, in_data, out_data, core_key, core_block;
   logic core_busy = 1'b0, core_valid = 1'b0;
   logic [127:0] core_block_out = '0;
   logic [CNT_W-1:0] blk_cnt;
   logic key_err;

   aes_stream_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .key_ready(key_ready),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .core_start(core_start), .core_key(core_key), .core_block(core_block),
      .core_busy(core_busy), .core_valid(core_valid), .core_block_out(core_block_out),
      .blk_cnt(blk_cnt), .key_err(key_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] stub_f(input logic [127:0] b, input logic [127:0] k);
      if (b == P1 && k == K1) return C1;
      return b ^ k;
   endfunction

   // Stub core: samples core_start on the falling edge, answers LAT falling edges later.
   logic [127:0] sb_blk, sb_key;
   int sb_cnt = 0, sb_hold = 0, hold_cfg = 0, n_start = 0, start_cyc = 0, neg = 0, ov_viol = 0;
   int start_log[$], valid_log[$];
   bit stray_req = 0;
   always @(negedge clk) begin
      neg++;
      core_valid = 1'b0;
      if (core_start) begin
         n_start++;
         start_cyc = cyc;
         start_log.push_back(neg);
         if (out_valid) ov_viol++;
         core_busy = 1'b1;
         sb_cnt = LAT;
         sb_blk = core_block;
         sb_key = core_key;
      end else if (sb_cnt > 0) begin
         sb_cnt--;
         if (sb_cnt == 0) begin
            core_valid = 1'b1;
            core_block_out = stub_f(sb_blk, sb_key);
            valid_log.push_back(neg);
            sb_hold = hold_cfg;
            if (hold_cfg == 0) core_busy = 1'b0;
         end
      end else if (sb_hold > 0) begin
         sb_hold--;
         if (sb_hold == 0) core_busy = 1'b0;
      end else if (stray_req) begin
         core_valid = 1'b1;
         core_block_out = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
         stray_req = 0;
      end
   end

   logic [127:0] got_q[$];
   always @(negedge clk) if (rst_n && out_valid && out_ready) got_q.push_back(out_data);

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [127:0] k);
      key_load = 1'b1;
      key_in   = k;
      tick(1);
      key_load = 1'b0;
   endtask

   task automatic push(input logic [127:0] d, output int wcyc, output int stalls);
      int budget = 300;
      bit ok = 0;
      stalls = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!ok && budget > 0) begin
         ok = in_ready;
         tick(1);
         if (!ok) stalls++;
         budget--;
      end
      wcyc = cyc;
      in_valid = 1'b0;
      chk("push_timeout", ok, 1);
   endtask

   task automatic wait_out(input int n);
      int budget = 500;
      while (got_q.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("wait_out", got_q.size() >= n, 1);
      tick(1);
   endtask

   task automatic wait_start(input int s0);
      int budget = 200;
      while (n_start <= s0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("wait_start", n_start > s0, 1);
      tick(1);
   endtask

   int wc, st, s0, base, first_stall, gap;
   logic [127:0] p2 [6];

   initial begin
      rst_n = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      core_key_dummy = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_key_err", key_err, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_key_ready", key_ready, 1);

      // Known-answer block
      load_key(K1);
      chk("t1_key", core_key, K1);
      s0 = n_start;
      push(P1, wc, st);
      wait_out(1);
      chk("t1_cipher", got_q[0], C1);
      tick(2);
      chk("t1_blk_cnt", blk_cnt, 1);
      chk("t1_starts", n_start - s0, 1);
      chk("t1_latency", start_cyc - wc, 1);

      // Back-to-back burst against a 4-deep FIFO
      s0 = n_start; base = got_q.size(); first_stall = -1;
      for (int i = 0; i < 6; i++) begin
         p2[i] = {4{32'h1000_0000 + 32'(i)}};
         push(p2[i], wc, st);
         if (st > 0 && first_stall < 0) first_stall = i;
      end
      chk("t2_writes_before_stall", first_stall, 5);
      wait_out(base + 6);
      for (int i = 0; i < 6; i++) chk("t2_order", got_q[base+i], p2[i] ^ K1);
      tick(2);
      chk("t2_blk_cnt", blk_cnt, 7);
      chk("t2_starts", n_start - s0, 6);

      // Output backpressure blocks further issue
      out_ready = 1'b0;
      s0 = n_start; base = got_q.size();
      push(128'haaaa, wc, st);
      push(128'hbbbb, wc, st);
      tick(25);
      chk("t3_held_valid", out_valid, 1);
      chk("t3_held_data", out_data, 128'haaaa ^ K1);
      chk("t3_no_issue", n_start - s0, 1);
      out_ready = 1'b1;
      wait_out(base + 2);
      chk("t3_first", got_q[base], 128'haaaa ^ K1);
      chk("t3_second", got_q[base+1], 128'hbbbb ^ K1);
      tick(2);
      chk("t3_blk_cnt", blk_cnt, 9);

      // Key load while a block is in flight
      s0 = n_start; base = got_q.size();
      push(128'h4444, wc, st);
      wait_start(s0);
      load_key(K2);
      chk("t4_key_kept", core_key, K1);
      chk("t4_key_err", key_err, 1);
      wait_out(base + 1);
      chk("t4_cipher", got_q[base], 128'h4444 ^ K1);
      tick(2);
      chk("t4_key_ready", key_ready, 1);
      load_key(K2);
      chk("t4_key_new", core_key, K2);
      chk("t4_err_sticky", key_err, 1);

      // Reset while waiting on the core; its late result and a stray pulse must be ignored
      s0 = n_start; base = got_q.size();
      push(128'h5555, wc, st);
      wait_start(s0);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      s0 = n_start;
      tick(12);
      stray_req = 1;
      tick(6);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_key_ready", key_ready, 1);
      chk("t5_in_ready", in_ready, 1);
      chk("t5_blk_cnt", blk_cnt, 0);
      chk("t5_key_err", key_err, 0);
      chk("t5_no_issue", n_start - s0, 0);
      chk("t5_no_output", got_q.size() - base, 0);

      // Core stays busy 3 cycles after its result
      load_key(K3);
      hold_cfg = 3;
      base = got_q.size();
      push(128'h6666, wc, st);
      push(128'h7777, wc, st);
      wait_out(base + 2);
      chk("t6_first", got_q[base], 128'h6666 ^ K3);
      chk("t6_second", got_q[base+1], 128'h7777 ^ K3);
      gap = start_log[start_log.size()-1] - valid_log[valid_log.size()-2];
      chk("t6_busy_gap", gap, 4);
      tick(2);
      chk("t6_blk_cnt", blk_cnt, 2);
      chk("no_start_while_out_valid", ov_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
